bool_expr_checker: RTL
======================

# bool_expr_checker

Self-checking result stage that sits directly downstream of a boolean-expression register stage. It samples the stage's reg_lvalue result through a valid/ready handshake and compares each sample against an expected value using 4-state (case-equality) semantics. It accumulates mismatches and then reports a single PASSED/FAILED verdict with first-failure diagnostics. The self-checking benches in this suite use it in place of ad-hoc `if` / `$display` checks.

## Interface
- WIDTH, 4: width of the checked value and the expected value.
- NUM_CHECKS, 8: samples per run; legal range 1..255.
- TIMEOUT, 16: consecutive idle cycles in CHECK before the run aborts; legal range 1..255.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; returns the block to IDLE immediately.
- start  in  1  single-cycle pulse that begins a run; honoured in IDLE and DONE only.
- in_valid  in  1  upstream has a sample.
- in_ready  out  1  block accepts a sample; high only in CHECK.
- in_value  in  WIDTH  result from the upstream boolean-expression stage.
- in_expect  in  WIDTH  expected value, qualified by in_valid.
- done  out  1  run finished, held until the next start or reset.
- passed  out  1  valid while done is high; 1 only if no mismatch and no timeout.
- timed_out  out  1  run aborted by the idle timeout.
- fail_count  out  8  number of mismatches, saturating at 255.
- first_fail_idx  out  8  sample index (0-based) of the first mismatch.
- first_fail_value  out  WIDTH  in_value captured at the first mismatch.

## Operation
- States: IDLE, CHECK, DONE. All outputs are registered except in_ready, which decodes as state==CHECK.
- Reset values:
  - state=IDLE.
  - done, passed, timed_out = 0.
  - fail_count = 0.
  - first_fail_idx = 0xFF.
  - first_fail_value = 0.
  - Internal sample_cnt = 0 and idle_cnt = 0.
- IDLE: start moves to CHECK. On that edge sample_cnt, idle_cnt and fail_count are cleared, first_fail_idx is set to 0xFF, and done, passed and timed_out are cleared.
- CHECK:
  - A sample transfers when in_valid && in_ready.
  - On a transfer, a mismatch is `in_value !== in_expect`. Any X or Z bit on either side that does not match exactly counts as a mismatch.
  - Each mismatch increments fail_count, saturating at 255.
  - The first mismatch of the run captures first_fail_idx=sample_cnt and first_fail_value=in_value. X/Z bits are stored as-is.
  - Every transfer increments sample_cnt and clears idle_cnt.
  - A cycle without in_valid increments idle_cnt.
  - start is ignored while in CHECK.
- CHECK -> DONE, transfer path: on the transfer where sample_cnt reaches NUM_CHECKS-1. done=1, and passed is 1 only if this final sample also matched and fail_count was 0.
- CHECK -> DONE, timeout path: when idle_cnt reaches TIMEOUT-1 on a non-transfer cycle. timed_out=1, done=1, passed=0.
- DONE: all results are held. start re-enters CHECK with the same clearing as from IDLE. in_valid is ignored.
- A reset asserted mid-run discards the run: no done pulse and no partial verdict.

## Timing
- Accept-to-update latency is 1 edge: a sample transferred at edge k is reflected in fail_count and first_fail_* after edge k.
- done rises on the same edge as the final transfer. There is no extra cycle.
- in_ready drops in the cycle after the final transfer, so at most NUM_CHECKS samples are consumed.
- For a run with no in_valid, done rises TIMEOUT edges after the start edge.
- start and the final transfer cannot coincide, because start is ignored in CHECK.
- A start arriving together with reset deassertion is seen only on the first clock edge after reset falls.

## Test plan
- Matching run: reset, start, then 8 transfers with in_value=in_expect=4'b0001 (the result of `1'b1 && 1'b1` zero-extended). Required: done=1 on the 8th transfer edge, passed=1, fail_count=0, first_fail_idx=0xFF.
- Mismatches: 8 transfers where only samples 2 and 5 carry in_value=4'b0000 against in_expect=4'b0001. Required: fail_count=2, first_fail_idx=2, first_fail_value=0, passed=0.
- 4-state compare: sample 0 has in_value=4'b000x and in_expect=4'b000x; sample 1 has in_value=4'b000x and in_expect=4'b0001. Required: sample 0 matches and sample 1 fails; first_fail_idx=1 and first_fail_value=4'b000x.
- Timeout: start, 3 transfers, then in_valid held low. Required: done=1 and timed_out=1 exactly 16 cycles after the 3rd transfer; passed=0; in_ready=0 thereafter.
- Reset and restart:
  - Assert reset after 4 transfers. Required: every output returns to its reset value asynchronously, with no done pulse.
  - Then run a matching run, and issue start in DONE. Required: all counters clear and a new 8-sample run completes.
- Backpressure: hold in_valid=1 for 12 cycles. Required: exactly 8 transfers, and in_ready=0 from the cycle after the 8th.

Source files
------------

// File: rtl/bool_expr_checker.sv
// Result stage that compares sampled values against expectations with case-equality
// semantics and reports one PASSED/FAILED verdict with first-failure diagnostics.
module bool_expr_checker #(
  parameter int WIDTH      = 4,
  parameter int NUM_CHECKS = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_value,
  input  logic [WIDTH-1:0] in_expect,
  output logic             done,
  output logic             passed,
  output logic             timed_out,
  output logic [7:0]       fail_count,
  output logic [7:0]       first_fail_idx,
  output logic [WIDTH-1:0] first_fail_value
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] LAST_IDX   = 8'(NUM_CHECKS - 1);
  localparam logic [7:0] IDLE_LIMIT = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] sample_cnt;
  logic [7:0] idle_cnt;
  logic       xfer;
  logic       mismatch;

  // X and Z bits must match exactly, so the compare is case inequality.
  function automatic logic differs(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (a !== b);
  endfunction

  assign in_ready = (state == CHECK);
  assign xfer     = in_valid && in_ready;
  assign mismatch = xfer && differs(in_value, in_expect);

  // Run control, sample/idle counting and verdict registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      sample_cnt       <= 8'd0;
      idle_cnt         <= 8'd0;
      done             <= 1'b0;
      passed           <= 1'b0;
      timed_out        <= 1'b0;
      fail_count       <= 8'd0;
      first_fail_idx   <= 8'hFF;
      first_fail_value <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= CHECK;
            sample_cnt     <= 8'd0;
            idle_cnt       <= 8'd0;
            fail_count     <= 8'd0;
            first_fail_idx <= 8'hFF;
            done           <= 1'b0;
            passed         <= 1'b0;
            timed_out      <= 1'b0;
          end else begin
            state <= state;
          end
        end
        CHECK: begin
          if (xfer) begin
            sample_cnt <= sample_cnt + 8'd1;
            idle_cnt   <= 8'd0;
            if (mismatch) begin
              if (fail_count != 8'hFF) begin
                fail_count <= fail_count + 8'd1;
              end else begin
                fail_count <= fail_count;
              end
              // fail_count is cleared at start, so zero marks the first mismatch.
              if (fail_count == 8'd0) begin
                first_fail_idx   <= sample_cnt;
                first_fail_value <= in_value;
              end else begin
                first_fail_idx <= first_fail_idx;
              end
            end else begin
              fail_count <= fail_count;
            end
            if (sample_cnt == LAST_IDX) begin
              state  <= DONE;
              done   <= 1'b1;
              passed <= !mismatch && (fail_count == 8'd0);
            end else begin
              state <= CHECK;
            end
          end else begin
            idle_cnt <= idle_cnt + 8'd1;
            if (idle_cnt == IDLE_LIMIT) begin
              state     <= DONE;
              done      <= 1'b1;
              timed_out <= 1'b1;
              passed    <= 1'b0;
            end else begin
              state <= CHECK;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
